// File: rtl/vga_pkg.sv
// Shared raster constants: default 1280x800@60 timing, derived totals, colour width.
// Also holds the playfield border limits used by the colour stage.
package vga_pkg;

    localparam int DEF_H_ACTIVE = 1280;
    localparam int DEF_H_FP     = 72;
    localparam int DEF_H_SYNC   = 128;
    localparam int DEF_H_BP     = 200;
    localparam int DEF_V_ACTIVE = 800;
    localparam int DEF_V_FP     = 3;
    localparam int DEF_V_SYNC   = 6;
    localparam int DEF_V_BP     = 22;

    function automatic int timing_total(input int act, input int fp, input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

    localparam int DEF_H_TOTAL = timing_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
    localparam int DEF_V_TOTAL = timing_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

    localparam int X_CNT_W = 11;
    localparam int Y_CNT_W = 10;
    localparam int COLOR_W = 4;

    localparam int BORDER_W = 16;
    localparam int XMIN     = BORDER_W;
    localparam int XMAX     = DEF_H_ACTIVE - BORDER_W - 1;
    localparam int YMIN     = BORDER_W;
    localparam int YMAX     = DEF_V_ACTIVE - BORDER_W - 1;

endpackage

// File: rtl/vga_timing_gen_sig_delay.sv
// Fixed-depth shift register with async active-low clear to a per-bit reset value.
// o_pre taps one stage before the output (the input itself when DEPTH is 1).
module sig_delay #(
    parameter int               DEPTH   = 2,
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_dat,
    output logic [WIDTH-1:0] o_dat,
    output logic [WIDTH-1:0] o_pre
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_stage[i] <= RST_VAL;
        end else begin
            r_stage[0] <= i_dat;
            for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
        end
    end

    assign o_dat = r_stage[DEPTH-1];

    generate
        if (DEPTH == 1) begin : g_pre_in
            assign o_pre = i_dat;
        end else begin : g_pre_stage
            assign o_pre = r_stage[DEPTH-2];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Raster counters, region decode and pin-aligned sync/blank/colour output stage.
// Coordinates reach the pins PIPE_DLY cycles later; frame_tick marks the first blank line.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic H_POL    = 1'b0,
    parameter logic V_POL    = 1'b1,
    parameter int   PIPE_DLY = 2
) (
    input  logic               clk_83,
    input  logic               rst_n,
    output logic [X_CNT_W-1:0] draw_x,
    output logic [Y_CNT_W-1:0] draw_y,
    input  logic [COLOR_W-1:0] in_r,
    input  logic [COLOR_W-1:0] in_g,
    input  logic [COLOR_W-1:0] in_b,
    output logic [COLOR_W-1:0] vga_r,
    output logic [COLOR_W-1:0] vga_g,
    output logic [COLOR_W-1:0] vga_b,
    output logic               vga_hs,
    output logic               vga_vs,
    output logic               active,
    output logic               frame_tick
);

    localparam int H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    generate
        if (PIPE_DLY < 1 || PIPE_DLY > 4) begin : g_bad_dly
            $error("vga_timing_gen: PIPE_DLY must be within 1..4");
        end
        if (H_TOTAL > (1 << X_CNT_W) || V_TOTAL > (1 << Y_CNT_W)) begin : g_bad_total
            $error("vga_timing_gen: raster totals exceed counter width");
        end
    endgenerate

    localparam logic [X_CNT_W-1:0] X_LAST   = X_CNT_W'(H_TOTAL - 1);
    localparam logic [X_CNT_W-1:0] X_VIS    = X_CNT_W'(H_ACTIVE);
    localparam logic [X_CNT_W-1:0] X_HS_BEG = X_CNT_W'(H_ACTIVE + H_FP);
    localparam logic [X_CNT_W-1:0] X_HS_END = X_CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [Y_CNT_W-1:0] Y_LAST   = Y_CNT_W'(V_TOTAL - 1);
    localparam logic [Y_CNT_W-1:0] Y_VIS    = Y_CNT_W'(V_ACTIVE);
    localparam logic [Y_CNT_W-1:0] Y_VS_BEG = Y_CNT_W'(V_ACTIVE + V_FP);
    localparam logic [Y_CNT_W-1:0] Y_VS_END = Y_CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [X_CNT_W-1:0] r_x;
    logic [Y_CNT_W-1:0] r_y;

    always_ff @(posedge clk_83 or negedge rst_n) begin
        if (!rst_n) begin
            r_x <= '0;
            r_y <= '0;
        end else if (r_x == X_LAST) begin
            r_x <= '0;
            r_y <= (r_y == Y_LAST) ? '0 : r_y + 1'b1;
        end else begin
            r_x <= r_x + 1'b1;
        end
    end

    logic w_vis;
    logic w_hs_raw;
    logic w_vs_raw;

    assign w_vis    = (r_x < X_VIS) && (r_y < Y_VIS);
    assign w_hs_raw = (r_x >= X_HS_BEG) && (r_x < X_HS_END);
    // Depends on y only, so it can only change when y steps at x = 0.
    assign w_vs_raw = (r_y >= Y_VS_BEG) && (r_y < Y_VS_END);

    // Polarity is applied before the delay line so the pins come straight off a flop.
    logic [2:0] w_dly_in;
    logic [2:0] w_dly_out;
    logic [2:0] w_dly_pre;

    assign w_dly_in = {w_vis,
                       w_hs_raw ? H_POL : ~H_POL,
                       w_vs_raw ? V_POL : ~V_POL};

    sig_delay #(
        .DEPTH   (PIPE_DLY),
        .WIDTH   (3),
        .RST_VAL ({1'b0, ~H_POL, ~V_POL})
    ) u_sig_delay (
        .i_clk   (clk_83),
        .i_rst_n (rst_n),
        .i_dat   (w_dly_in),
        .o_dat   (w_dly_out),
        .o_pre   (w_dly_pre)
    );

    logic w_vis_pre;
    assign w_vis_pre = w_dly_pre[2];

    logic [COLOR_W-1:0] r_r;
    logic [COLOR_W-1:0] r_g;
    logic [COLOR_W-1:0] r_b;

    always_ff @(posedge clk_83 or negedge rst_n) begin
        if (!rst_n) begin
            r_r <= '0;
            r_g <= '0;
            r_b <= '0;
        end else if (w_vis_pre) begin
            r_r <= in_r;
            r_g <= in_g;
            r_b <= in_b;
        end else begin
            r_r <= '0;
            r_g <= '0;
            r_b <= '0;
        end
    end

    assign draw_x     = r_x;
    assign draw_y     = r_y;
    assign vga_r      = r_r;
    assign vga_g      = r_g;
    assign vga_b      = r_b;
    assign active     = w_dly_out[2];
    assign vga_hs     = w_dly_out[1];
    assign vga_vs     = w_dly_out[0];
    assign frame_tick = (r_x == '0) && (r_y == Y_VIS);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a shrunken 25x15 raster (16x10 visible, PIPE_DLY=2).
module tb_vga_timing_gen;

    logic        clk_83;
    logic        rst_n;
    logic [10:0] draw_x;
    logic [9:0]  draw_y;
    logic [11:0] in_rgb;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        vga_hs, vga_vs, active, frame_tick;

    vga_timing_gen #(
        .H_ACTIVE (16), .H_FP (2), .H_SYNC (4), .H_BP (3),
        .V_ACTIVE (10), .V_FP (1), .V_SYNC (2), .V_BP (2),
        .H_POL    (1'b0), .V_POL (1'b1), .PIPE_DLY (2)
    ) dut (
        .clk_83     (clk_83),
        .rst_n      (rst_n),
        .draw_x     (draw_x),
        .draw_y     (draw_y),
        .in_r       (in_rgb[11:8]),
        .in_g       (in_rgb[7:4]),
        .in_b       (in_rgb[3:0]),
        .vga_r      (vga_r),
        .vga_g      (vga_g),
        .vga_b      (vga_b),
        .vga_hs     (vga_hs),
        .vga_vs     (vga_vs),
        .active     (active),
        .frame_tick (frame_tick)
    );

    initial clk_83 = 1'b0;
    always #5 clk_83 = ~clk_83;

    // Edges since reset release: at cycle c the counters hold coordinate c, pins show c-2.
    int cyc;
    always @(posedge clk_83 or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cyc=%0d)", name, got, exp, cyc);
        end
    endtask

    function automatic int pins_rgb();
        return int'({vga_r, vga_g, vga_b});
    endfunction

    task automatic wait_cyc(input int c);
        if (cyc > c) check("wait_target_passed", cyc, c);
        while (cyc < c) @(negedge clk_83);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_x"},    int'(draw_x), 0);
        check({tag, "_y"},    int'(draw_y), 0);
        check({tag, "_rgb"},  pins_rgb(), 0);
        check({tag, "_hs"},   int'(vga_hs), 1);
        check({tag, "_vs"},   int'(vga_vs), 0);
        check({tag, "_act"},  int'(active), 0);
        check({tag, "_tick"}, int'(frame_tick), 0);
    endtask

    // One-frame tallies over pin cycles 2..376 (coordinates 0..374).
    int  mon_hs_low  = 0;
    int  mon_vs_high = 0;
    int  mon_active  = 0;
    int  mon_ticks   = 0;
    int  mon_blank_bad = 0;
    logic mon_en = 1'b0;

    always @(negedge clk_83) begin
        if (mon_en && rst_n && cyc >= 2 && cyc <= 376) begin
            if (!vga_hs)    mon_hs_low++;
            if (vga_vs)     mon_vs_high++;
            if (active)     mon_active++;
            if (frame_tick) mon_ticks++;
            if (!active && pins_rgb() != 0) mon_blank_bad++;
            if (active && pins_rgb() != 12'hFFF) mon_blank_bad++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    typedef struct {
        int cyc;
        int x;
        int y;
        int hs;
        int vs;
        int act;
        int tick;
        int rgb;
    } vec_t;

    vec_t vec [21];

    initial begin
        vec[0]  = '{1,   1,  0,  1, 0, 0, 0, 12'h000};
        vec[1]  = '{2,   2,  0,  1, 0, 1, 0, 12'hFFF};
        vec[2]  = '{17,  17, 0,  1, 0, 1, 0, 12'hFFF};
        vec[3]  = '{18,  18, 0,  1, 0, 0, 0, 12'h000};
        vec[4]  = '{19,  19, 0,  1, 0, 0, 0, 12'h000};
        vec[5]  = '{20,  20, 0,  0, 0, 0, 0, 12'h000};
        vec[6]  = '{23,  23, 0,  0, 0, 0, 0, 12'h000};
        vec[7]  = '{24,  24, 0,  1, 0, 0, 0, 12'h000};
        vec[8]  = '{25,  0,  1,  1, 0, 0, 0, 12'h000};
        vec[9]  = '{27,  2,  1,  1, 0, 1, 0, 12'hFFF};
        vec[10] = '{250, 0,  10, 1, 0, 0, 1, 12'h000};
        vec[11] = '{251, 1,  10, 1, 0, 0, 0, 12'h000};
        vec[12] = '{252, 2,  10, 1, 0, 0, 0, 12'h000};
        vec[13] = '{276, 1,  11, 1, 0, 0, 0, 12'h000};
        vec[14] = '{277, 2,  11, 1, 1, 0, 0, 12'h000};
        vec[15] = '{326, 1,  13, 1, 1, 0, 0, 12'h000};
        vec[16] = '{327, 2,  13, 1, 0, 0, 0, 12'h000};
        vec[17] = '{374, 24, 14, 1, 0, 0, 0, 12'h000};
        vec[18] = '{375, 0,  0,  1, 0, 0, 0, 12'h000};
        vec[19] = '{377, 2,  0,  1, 0, 1, 0, 12'hFFF};
        vec[20] = '{625, 0,  10, 1, 0, 0, 1, 12'h000};

        in_rgb = 12'hFFF;
        rst_n  = 1'b0;
        repeat (10) @(negedge clk_83);
        check_reset_vals("reset");
        mon_en = 1'b1;
        rst_n  = 1'b1;

        for (int i = 0; i < 21; i++) begin
            wait_cyc(vec[i].cyc);
            check($sformatf("v%0d_x", i),    int'(draw_x),     vec[i].x);
            check($sformatf("v%0d_y", i),    int'(draw_y),     vec[i].y);
            check($sformatf("v%0d_hs", i),   int'(vga_hs),     vec[i].hs);
            check($sformatf("v%0d_vs", i),   int'(vga_vs),     vec[i].vs);
            check($sformatf("v%0d_act", i),  int'(active),     vec[i].act);
            check($sformatf("v%0d_tick", i), int'(frame_tick), vec[i].tick);
            check($sformatf("v%0d_rgb", i),  pins_rgb(),       vec[i].rgb);
        end

        check("frame_hs_low_cycles",  mon_hs_low,    60);
        check("frame_vs_high_cycles", mon_vs_high,   50);
        check("frame_active_cycles",  mon_active,    160);
        check("frame_tick_count",     mon_ticks,     1);
        check("frame_blank_override", mon_blank_bad, 0);

        // Colour alignment: red only for the colour belonging to coordinate (0,0) of frame 2.
        for (int c = 745; c <= 760; c++) begin
            wait_cyc(c);
            if (c == 751) begin
                check("align_pre_rgb", pins_rgb(), 12'h000);
                check("align_pre_act", int'(active), 0);
            end
            if (c == 752) begin
                check("align_red_rgb", pins_rgb(), 12'hF00);
                check("align_red_act", int'(active), 1);
            end
            if (c == 753) begin
                check("align_post_rgb", pins_rgb(), 12'h000);
                check("align_post_act", int'(active), 1);
            end
            in_rgb = (draw_x == 11'd1 && draw_y == 10'd0) ? 12'hF00 : 12'h000;
        end
        in_rgb = 12'hFFF;

        // Mid-line asynchronous reset at (7,4) of frame 2.
        wait_cyc(857);
        check("pre_arst_x",   int'(draw_x), 7);
        check("pre_arst_y",   int'(draw_y), 4);
        check("pre_arst_act", int'(active), 1);
        check("pre_arst_rgb", pins_rgb(),   12'hFFF);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("arst");
        repeat (3) @(negedge clk_83);
        check_reset_vals("arst_hold");
        rst_n = 1'b1;

        wait_cyc(1);
        check("rel_x1", int'(draw_x), 1);
        check("rel_y1", int'(draw_y), 0);
        wait_cyc(2);
        check("rel_act2", int'(active), 1);
        check("rel_rgb2", pins_rgb(),   12'hFFF);
        wait_cyc(25);
        check("rel_wrap_x", int'(draw_x), 0);
        check("rel_wrap_y", int'(draw_y), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
